// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the register-file write arbiter and its neighbours:
// pipeline writeback, multicycle result handshake, decode RAW query and regfile write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_reg;
  logic [DATA_W-1:0] mc_data;

  logic [ADDR_W-1:0] rd_reg1;
  logic [ADDR_W-1:0] rd_reg2;
  logic              rd_pending1;
  logic              rd_pending2;

  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  count;

  // Master drives the sources and decode queries; slave is the arbiter.
  modport master (
    output wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data, rd_reg1, rd_reg2,
    input  mc_ready, rd_pending1, rd_pending2, reg_write, write_reg, write_data, count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data, rd_reg1, rd_reg2,
    output mc_ready, rd_pending1, rd_pending2, reg_write, write_reg, write_data, count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single regfile write port: pipeline writeback has priority, multicycle results
// wait in a FIFO whose entries are squashed by younger pipeline writes (WAW).
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] entry_reg_q  [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];
  logic [DEPTH-1:0]  entry_vld_q, entry_vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic mc_ready, push, pop, wb_issue;
  logic pend1, pend2;

  assign mc_ready = reset && (count_q < CNT_W'(DEPTH));
  assign wb_issue = bus.wb_valid && (bus.wb_reg != '0);
  // r0 results complete the handshake but never occupy a slot.
  assign push     = bus.mc_valid && mc_ready && (bus.mc_reg != '0);
  assign pop      = !wb_issue && (count_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    entry_vld_d  = entry_vld_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (wb_issue) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.wb_reg;
      write_data_d = bus.wb_data;
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_reg_q[i] == bus.wb_reg) entry_vld_d[i] = 1'b0;
      end
    end else if (pop) begin
      reg_write_d = entry_vld_q[head_q];
      if (entry_vld_q[head_q]) begin
        write_reg_d  = entry_reg_q[head_q];
        write_data_d = entry_data_q[head_q];
      end
      entry_vld_d[head_q] = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end

    // Applied after the squash so a same-cycle enqueue to wb_reg survives.
    if (push) begin
      entry_vld_d[tail_q] = 1'b1;
      tail_d              = tail_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_vld_q  <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      entry_vld_q  <= entry_vld_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // NOTE: the payload array has no reset; the valid bits and count alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg_q[tail_q]  <= bus.mc_reg;
      entry_data_q[tail_q] <= bus.mc_data;
    end
  end

  // A register is pending while queued or while its write sits in the output stage.
  always_comb begin
    pend1 = reg_write_q && (write_reg_q == bus.rd_reg1);
    pend2 = reg_write_q && (write_reg_q == bus.rd_reg2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld_q[i] && (entry_reg_q[i] == bus.rd_reg1)) pend1 = 1'b1;
      if (entry_vld_q[i] && (entry_reg_q[i] == bus.rd_reg2)) pend2 = 1'b1;
    end
  end

  assign bus.rd_pending1 = (bus.rd_reg1 != '0) && pend1;
  assign bus.rd_pending2 = (bus.rd_reg2 != '0) && pend2;
  assign bus.mc_ready    = mc_ready;
  assign bus.reg_write   = reg_write_q;
  assign bus.write_reg   = write_reg_q;
  assign bus.write_data  = write_data_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: priority, FIFO order, WAW squash,
// r0 handling and reset discard, with hand-computed expectations.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

  regfile_write_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample in the same window.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.mc_valid = 1'b0; bus.mc_reg = '0; bus.mc_data = '0;
  endtask

  task automatic mc(input logic [4:0] r, input logic [31:0] d);
    bus.mc_valid = 1'b1; bus.mc_reg = r; bus.mc_data = d;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = 1'b1; bus.wb_reg = r; bus.wb_data = d;
  endtask

  initial begin
    idle();
    bus.rd_reg1 = '0; bus.rd_reg2 = '0;
    reset = 1'b0;

    // 1. reset with a result offered
    mc(5'd9, 32'h99);
    step(); step();
    check("rst_ready", 32'(bus.mc_ready), 32'd0);
    check("rst_wr", 32'(bus.reg_write), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_wreg", 32'(bus.write_reg), 32'd0);
    check("rst_wdata", bus.write_data, 32'd0);
    reset = 1'b1; idle();
    #1;
    check("rel_ready", 32'(bus.mc_ready), 32'd1);

    // 2. single multicycle result, latency and pending
    bus.rd_reg1 = 5'd3;
    mc(5'd3, 32'hAA);
    step(); idle(); #1;
    check("t2_count", 32'(bus.count), 32'd1);
    check("t2_pend_q", 32'(bus.rd_pending1), 32'd1);
    check("t2_nowr", 32'(bus.reg_write), 32'd0);
    step();
    check("t2_wr", 32'(bus.reg_write), 32'd1);
    check("t2_wreg", 32'(bus.write_reg), 32'd3);
    check("t2_wdata", bus.write_data, 32'hAA);
    check("t2_pend_wr", 32'(bus.rd_pending1), 32'd1);
    check("t2_count0", 32'(bus.count), 32'd0);
    step();
    check("t2_wr_off", 32'(bus.reg_write), 32'd0);
    check("t2_pend_off", 32'(bus.rd_pending1), 32'd0);

    // 3. pipeline overtakes a queued r4
    mc(5'd4, 32'h44);
    step(); idle();
    wb(5'd7, 32'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_wb_wreg", 32'(bus.write_reg), 32'd7);
      check("t3_wb_count", 32'(bus.count), 32'd1);
    end
    idle();
    step();
    check("t3_q_wr", 32'(bus.reg_write), 32'd1);
    check("t3_q_wreg", 32'(bus.write_reg), 32'd4);
    check("t3_q_wdata", bus.write_data, 32'h44);
    check("t3_count0", 32'(bus.count), 32'd0);
    step();
    check("t3_idle_wr", 32'(bus.reg_write), 32'd0);
    check("t3_hold_wreg", 32'(bus.write_reg), 32'd4);
    check("t3_hold_wdata", bus.write_data, 32'h44);

    // 4. fill to full under continuous wb, then drain in order
    wb(5'd7, 32'h11);
    for (int i = 1; i <= 4; i++) begin
      mc(5'(i), 32'h10 * 32'(i));
      step();
    end
    bus.mc_valid = 1'b0;
    #1;
    check("t4_full_count", 32'(bus.count), 32'd4);
    check("t4_full_ready", 32'(bus.mc_ready), 32'd0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_drain_wr", 32'(bus.reg_write), 32'd1);
      check("t4_drain_wreg", 32'(bus.write_reg), 32'(i));
      check("t4_drain_wdata", bus.write_data, 32'h10 * 32'(i));
      check("t4_drain_count", 32'(bus.count), 32'(4 - i));
      check("t4_drain_ready", 32'(bus.mc_ready), 32'd1);
    end
    step();
    check("t4_empty_wr", 32'(bus.reg_write), 32'd0);

    // 5. WAW squash of a queued r5
    bus.rd_reg1 = 5'd5;
    mc(5'd5, 32'h55);
    step(); idle(); #1;
    check("t5_pend_q", 32'(bus.rd_pending1), 32'd1);
    wb(5'd5, 32'h99);
    step(); idle(); #1;
    check("t5_wb_wdata", bus.write_data, 32'h99);
    check("t5_pend_wb", 32'(bus.rd_pending1), 32'd1);
    check("t5_count_sq", 32'(bus.count), 32'd1);
    step();
    check("t5_sq_wr", 32'(bus.reg_write), 32'd0);
    check("t5_sq_count", 32'(bus.count), 32'd0);
    check("t5_final_data", bus.write_data, 32'h99);
    check("t5_pend_done", 32'(bus.rd_pending1), 32'd0);

    // same-cycle enqueue and wb to r6: entry must survive
    bus.rd_reg2 = 5'd6;
    mc(5'd6, 32'h66);
    wb(5'd6, 32'h60);
    step(); idle(); #1;
    check("t5b_count", 32'(bus.count), 32'd1);
    check("t5b_wb_wdata", bus.write_data, 32'h60);
    check("t5b_pend2", 32'(bus.rd_pending2), 32'd1);
    step();
    check("t5b_pop_wr", 32'(bus.reg_write), 32'd1);
    check("t5b_pop_wdata", bus.write_data, 32'h66);

    // 6. r0 handling
    bus.rd_reg1 = 5'd0;
    mc(5'd0, 32'hDEAD);
    wb(5'd0, 32'hBEEF);
    #1;
    check("t6_r0_ready", 32'(bus.mc_ready), 32'd1);
    check("t6_r0_pend", 32'(bus.rd_pending1), 32'd0);
    step(); idle(); #1;
    check("t6_r0_count", 32'(bus.count), 32'd0);
    check("t6_r0_wr", 32'(bus.reg_write), 32'd0);
    check("t6_r0_pend2", 32'(bus.rd_pending1), 32'd0);
    mc(5'd8, 32'h88);
    step(); idle();
    wb(5'd0, 32'h1234);
    step(); idle(); #1;
    check("t6_r0wb_pop_wr", 32'(bus.reg_write), 32'd1);
    check("t6_r0wb_pop_wreg", 32'(bus.write_reg), 32'd8);
    step();

    // reset discards three queued results
    wb(5'd7, 32'h11);
    for (int i = 9; i <= 11; i++) begin
      mc(5'(i), 32'(i));
      step();
    end
    idle(); #1;
    check("t6_q3_count", 32'(bus.count), 32'd3);
    reset = 1'b0;
    mc(5'd12, 32'hC);
    #1;
    check("t6_rst_ready", 32'(bus.mc_ready), 32'd0);
    step();
    reset = 1'b1; idle();
    bus.rd_reg1 = 5'd9;
    #1;
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_wr", 32'(bus.reg_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_after_wr", 32'(bus.reg_write), 32'd0);
      check("t6_after_pend", 32'(bus.rd_pending1), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
